// File: rtl/maze_player.sv
// Player controller for the 10x15 maze: walks the generator's wall maps with four
// edge-triggered buttons, checks walls and borders, counts steps and flags the exit.
module maze_player #(
   parameter int EXIT_X   = 9,
   parameter int EXIT_Y   = 14,
   parameter int COOLDOWN = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         gen_busy,
   input  logic [159:0] h_walls,
   input  logic [164:0] v_walls,
   input  logic         btn_up,
   input  logic         btn_right,
   input  logic         btn_down,
   input  logic         btn_left,
   output logic [3:0]   player_x,
   output logic [3:0]   player_y,
   output logic [9:0]   steps,
   output logic         bump,
   output logic         playing,
   output logic         won
);

   typedef enum logic [1:0] {WAIT_GEN, PLAY, WON} state_t;

   state_t     state;
   logic       armed;
   logic [3:0] btn_q;
   logic [7:0] cooldown;

   logic [3:0] btn_now;
   logic [3:0] edges;
   logic [7:0] h_idx;
   logic [7:0] v_idx;
   logic       can_up, can_right, can_down, can_left;
   logic       move_req, move_ok;
   logic [3:0] next_x, next_y;

   assign btn_now = {btn_up, btn_right, btn_down, btn_left};
   assign edges   = btn_now & ~btn_q;

   // Wall lookups for the current cell; the maps are read live, never latched.
   always_comb begin
      h_idx     = 8'(player_y) * 8'd10 + 8'(player_x);
      v_idx     = 8'(player_y) * 8'd11 + 8'(player_x);
      can_up    = (player_y != 4'd0) && !h_walls[h_idx];
      can_down  = (player_y < 4'd14) && !h_walls[h_idx + 8'd10];
      can_left  = (player_x != 4'd0) && !v_walls[v_idx];
      can_right = (player_x < 4'd9)  && !v_walls[v_idx + 8'd1];
   end

   // Highest-priority edge wins: up > right > down > left.
   always_comb begin
      move_req = 1'b0;
      move_ok  = 1'b0;
      next_x   = player_x;
      next_y   = player_y;
      if (edges[3]) begin
         move_req = 1'b1;
         move_ok  = can_up;
         next_y   = player_y - 4'd1;
      end else if (edges[2]) begin
         move_req = 1'b1;
         move_ok  = can_right;
         next_x   = player_x + 4'd1;
      end else if (edges[1]) begin
         move_req = 1'b1;
         move_ok  = can_down;
         next_y   = player_y + 4'd1;
      end else if (edges[0]) begin
         move_req = 1'b1;
         move_ok  = can_left;
         next_x   = player_x - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= WAIT_GEN;
         armed    <= 1'b0;
         btn_q    <= 4'b1111;
         cooldown <= 8'd0;
         player_x <= 4'd0;
         player_y <= 4'd0;
         steps    <= 10'd0;
         bump     <= 1'b0;
         playing  <= 1'b0;
         won      <= 1'b0;
      end else begin
         btn_q <= btn_now;
         bump  <= 1'b0;
         case (state)
            WAIT_GEN: begin
               if (gen_busy) begin
                  armed <= 1'b1;
               end else if (armed) begin
                  armed   <= 1'b0;
                  state   <= PLAY;
                  playing <= 1'b1;
               end
            end
            PLAY, WON: begin
               // A new maze is being generated: restart from the entrance.
               if (gen_busy) begin
                  state    <= WAIT_GEN;
                  armed    <= 1'b1;
                  player_x <= 4'd0;
                  player_y <= 4'd0;
                  steps    <= 10'd0;
                  cooldown <= 8'd0;
                  playing  <= 1'b0;
                  won      <= 1'b0;
               end else if (state == PLAY) begin
                  if (cooldown != 8'd0) begin
                     cooldown <= cooldown - 8'd1;
                  end else if (move_req && move_ok) begin
                     player_x <= next_x;
                     player_y <= next_y;
                     cooldown <= 8'(COOLDOWN);
                     if (steps != 10'd1023) begin
                        steps <= steps + 10'd1;
                     end
                     if (next_x == 4'(EXIT_X) && next_y == 4'(EXIT_Y)) begin
                        state   <= WON;
                        playing <= 1'b0;
                        won     <= 1'b1;
                     end
                  end else if (move_req) begin
                     bump <= 1'b1;
                  end
               end
            end
            default: begin
               state <= WAIT_GEN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_maze_player.sv
// Directed bench for maze_player: stimulus pushes hand-computed expectations into a
// scoreboard queue, and a negedge monitor pops and compares them against the outputs.
module tb_maze_player;

   localparam logic [3:0] UP    = 4'b1000;
   localparam logic [3:0] RIGHT = 4'b0100;
   localparam logic [3:0] DOWN  = 4'b0010;
   localparam logic [3:0] LEFT  = 4'b0001;
   localparam logic [3:0] NONE  = 4'b0000;

   typedef struct packed {
      logic [3:0] x;
      logic [3:0] y;
      logic [9:0] steps;
      logic       bump;
      logic       playing;
      logic       won;
   } expect_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         gen_busy;
   logic [159:0] h_walls;
   logic [164:0] v_walls;
   logic         btn_up, btn_right, btn_down, btn_left;
   logic [3:0]   player_x, player_y;
   logic [9:0]   steps;
   logic         bump, playing, won;

   expect_t exp_q[$];
   string   tag_q[$];
   int      checks   = 0;
   int      failures = 0;

   always #5 clk = ~clk;

   maze_player #(.EXIT_X(9), .EXIT_Y(14), .COOLDOWN(4)) dut (
      .clk(clk), .rst(rst), .gen_busy(gen_busy),
      .h_walls(h_walls), .v_walls(v_walls),
      .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down), .btn_left(btn_left),
      .player_x(player_x), .player_y(player_y), .steps(steps),
      .bump(bump), .playing(playing), .won(won)
   );

   // Monitor: compares the oldest pending expectation on the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         expect_t e;
         expect_t got;
         string   t;
         e   = exp_q.pop_front();
         t   = tag_q.pop_front();
         got = {player_x, player_y, steps, bump, playing, won};
         checks++;
         if (got !== e) begin
            failures++;
            $display("[TB] FAIL %s: got x=%0d y=%0d steps=%0d bump=%0b playing=%0b won=%0b, want x=%0d y=%0d steps=%0d bump=%0b playing=%0b won=%0b",
                     t, got.x, got.y, got.steps, got.bump, got.playing, got.won,
                     e.x, e.y, e.steps, e.bump, e.playing, e.won);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] btns, input logic busy, input int cycles);
      {btn_up, btn_right, btn_down, btn_left} = btns;
      gen_busy = busy;
      repeat (cycles) tick();
   endtask

   task automatic checkOutput(input string tag, input int ex, input int ey, input int es,
                              input logic eb, input logic ep, input logic ew);
      expect_t e;
      e = {4'(ex), 4'(ey), 10'(es), eb, ep, ew};
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      #1;
   endtask

   // Press, check the response, release, check bump cleared, then let cooldown expire.
   task automatic doMove(input string tag, input logic [3:0] btns, input int ex, input int ey,
                         input int es, input logic eb, input logic ew);
      applyStimulus(btns, 1'b0, 1);
      checkOutput(tag, ex, ey, es, eb, !ew, ew);
      applyStimulus(NONE, 1'b0, 1);
      checkOutput({tag, "_rel"}, ex, ey, es, 1'b0, !ew, ew);
      applyStimulus(NONE, 1'b0, 4);
   endtask

   initial begin
      rst      = 1'b1;
      gen_busy = 1'b0;
      h_walls  = '0;
      v_walls  = '0;
      {btn_up, btn_right, btn_down, btn_left} = 4'b1111;
      tick();
      tick();
      checkOutput("reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);

      rst = 1'b0;
      applyStimulus(4'b1111, 1'b0, 100);
      checkOutput("no_arm", 0, 0, 0, 1'b0, 1'b0, 1'b0);

      h_walls[0] = 1'b1;
      applyStimulus(NONE, 1'b1, 400);
      checkOutput("busy_hold", 0, 0, 0, 1'b0, 1'b0, 1'b0);
      applyStimulus(NONE, 1'b0, 1);
      checkOutput("play_rise", 0, 0, 0, 1'b0, 1'b1, 1'b0);

      doMove("left_border", LEFT, 0, 0, 0, 1'b1, 1'b0);
      doMove("up_wall", UP, 0, 0, 0, 1'b1, 1'b0);

      applyStimulus(RIGHT, 1'b0, 1);
      checkOutput("right_open", 1, 0, 1, 1'b0, 1'b1, 1'b0);
      applyStimulus(RIGHT, 1'b0, 50);
      checkOutput("right_hold", 1, 0, 1, 1'b0, 1'b1, 1'b0);
      applyStimulus(NONE, 1'b0, 5);

      doMove("down_open", DOWN, 1, 1, 2, 1'b0, 1'b0);
      doMove("prio_up", UP | RIGHT, 1, 0, 3, 1'b0, 1'b0);
      doMove("prio_up_blocked", UP | RIGHT, 1, 0, 3, 1'b1, 1'b0);

      applyStimulus(RIGHT, 1'b0, 1);
      checkOutput("cd_move", 2, 0, 4, 1'b0, 1'b1, 1'b0);
      applyStimulus(NONE, 1'b0, 1);
      applyStimulus(RIGHT, 1'b0, 1);
      checkOutput("cd_ignore", 2, 0, 4, 1'b0, 1'b1, 1'b0);
      applyStimulus(NONE, 1'b0, 5);

      v_walls[3] = 1'b1;
      doMove("v_wall_right", RIGHT, 2, 0, 4, 1'b1, 1'b0);
      v_walls[3] = 1'b0;
      h_walls[12] = 1'b1;
      doMove("h_wall_down", DOWN, 2, 0, 4, 1'b1, 1'b0);
      h_walls[12] = 1'b0;

      for (int i = 0; i < 7; i++) doMove("walk_right", RIGHT, 3 + i, 0, 5 + i, 1'b0, 1'b0);
      doMove("right_border", RIGHT, 9, 0, 11, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) doMove("walk_down", DOWN, 9, 1 + i, 12 + i, 1'b0, 1'b0);

      h_walls[69] = 1'b1;
      doMove("h_wall_row5", DOWN, 9, 5, 16, 1'b1, 1'b0);
      h_walls[69] = 1'b0;
      v_walls[64] = 1'b1;
      doMove("v_wall_row5", LEFT, 9, 5, 16, 1'b1, 1'b0);
      v_walls[64] = 1'b0;

      for (int i = 0; i < 9; i++)
         doMove("walk_exit", DOWN, 9, 6 + i, 17 + i, 1'b0, (i == 8));
      doMove("won_frozen_left", LEFT, 9, 14, 25, 1'b0, 1'b1);
      doMove("won_frozen_up", UP, 9, 14, 25, 1'b0, 1'b1);

      applyStimulus(NONE, 1'b1, 1);
      checkOutput("regen", 0, 0, 0, 1'b0, 1'b0, 1'b0);
      applyStimulus(NONE, 1'b0, 1);
      checkOutput("replay", 0, 0, 0, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < 9; i++) doMove("run_right", RIGHT, 1 + i, 0, 1 + i, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++)
         doMove("run_down", DOWN, 9, 1 + i, 10 + i, 1'b0, (i == 13));

      applyStimulus(NONE, 1'b1, 3);
      applyStimulus(NONE, 1'b0, 1);
      checkOutput("replay2", 0, 0, 0, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < 1030; i++) begin
         applyStimulus((i % 2 == 0) ? RIGHT : LEFT, 1'b0, 1);
         if (i == 9)    checkOutput("sat_10", 0, 0, 10, 1'b0, 1'b1, 1'b0);
         if (i == 1022) checkOutput("sat_1023", 1, 0, 1023, 1'b0, 1'b1, 1'b0);
         applyStimulus(NONE, 1'b0, 4);
      end
      checkOutput("sat_hold", 0, 0, 1023, 1'b0, 1'b1, 1'b0);

      applyStimulus(RIGHT, 1'b0, 1);
      checkOutput("pre_rst_move", 1, 0, 1023, 1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      applyStimulus(NONE, 1'b0, 1);
      checkOutput("rst_mid", 0, 0, 0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      applyStimulus(NONE, 1'b0, 10);
      checkOutput("rst_no_arm", 0, 0, 0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
